// File: rtl/axis_keep_packer.sv
// Purpose: compacts sparse-tkeep AXI-Stream beats into dense full-width beats, preserving tlast.
// Latency: one cycle from input acceptance to visibility on m_axis_tdata.
// Backpressure: s_axis_tready is driven from registered state only (free space and no pending tlast).
// Ports: aclk/aresetn clock and async active-low reset; s_axis_* sparse input stream
//        (tvalid/tready/tdata/tkeep/tlast); m_axis_* dense output stream, word 0 oldest,
//        tkeep all ones except a low-aligned final partial beat.
module axis_keep_packer #(
  parameter int WORDS      = 16,
  parameter int WORD_WIDTH = 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [WORDS*WORD_WIDTH-1:0] s_axis_tdata,
  input  logic [WORDS-1:0]            s_axis_tkeep,
  input  logic                        s_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [WORDS*WORD_WIDTH-1:0] m_axis_tdata,
  output logic [WORDS-1:0]            m_axis_tkeep,
  output logic                        m_axis_tlast
);

  localparam int SLOTS = 2 * WORDS;
  localparam int AW    = $clog2(SLOTS);
  localparam int CW    = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(WORDS);

  logic [WORD_WIDTH-1:0] buf_q [SLOTS];
  logic [WORD_WIDTH-1:0] buf_d [SLOTS];
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         popped, base, k;
  logic [AW-1:0]         slot;
  logic                  last_pending_q, last_pending_d;
  logic                  push, pop;

  // Output beat is the front of the buffer; everything derives from registered state.
  assign s_axis_tready = !last_pending_q && (count_q <= FULL);
  assign m_axis_tvalid = (count_q >= FULL) || last_pending_q;
  assign m_axis_tlast  = last_pending_q && (count_q <= FULL);

  always_comb begin
    m_axis_tkeep = '0;
    m_axis_tdata = '0;
    for (int i = 0; i < WORDS; i++) begin
      m_axis_tkeep[i] = (count_q >= FULL) || (CW'(i) < count_q);
      m_axis_tdata[i*WORD_WIDTH +: WORD_WIDTH] = buf_q[i];
    end
  end

  assign push = s_axis_tvalid && s_axis_tready;
  assign pop  = m_axis_tvalid && m_axis_tready;

  always_comb begin
    popped = '0;
    if (pop) begin
      popped = (count_q >= FULL) ? FULL : count_q;
    end
    base = count_q - popped;

    for (int j = 0; j < SLOTS; j++) begin
      buf_d[j] = buf_q[j];
    end
    // A pop always shifts by a full beat: when fewer than WORDS words were
    // present the buffer becomes empty, so the shifted-in slots are dead anyway.
    if (pop) begin
      for (int j = 0; j < WORDS; j++) begin
        buf_d[j] = buf_q[j+WORDS];
      end
      for (int j = WORDS; j < SLOTS; j++) begin
        buf_d[j] = '0;
      end
    end

    // Scatter kept words after the post-pop fill level; k is the running
    // prefix count of kept words, so word i lands at base + popcount(keep[i-1:0]).
    k    = '0;
    slot = '0;
    for (int i = 0; i < WORDS; i++) begin
      slot = AW'(base + k);
      if (push && s_axis_tkeep[i]) begin
        buf_d[slot] = s_axis_tdata[i*WORD_WIDTH +: WORD_WIDTH];
      end
      k = k + CW'(s_axis_tkeep[i]);
    end

    count_d = base;
    if (push) begin
      count_d = base + k;
    end

    // A push never coincides with a pending tlast (input is stalled), so
    // the clear and set below cannot conflict.
    last_pending_d = last_pending_q;
    if (pop && m_axis_tlast) begin
      last_pending_d = 1'b0;
    end
    if (push && s_axis_tlast) begin
      last_pending_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count_q        <= '0;
      last_pending_q <= 1'b0;
      for (int j = 0; j < SLOTS; j++) begin
        buf_q[j] <= '0;
      end
    end else begin
      count_q        <= count_d;
      last_pending_q <= last_pending_d;
      for (int j = 0; j < SLOTS; j++) begin
        buf_q[j] <= buf_d[j];
      end
    end
  end

endmodule

// File: doc/axis_keep_packer.md
Name: axis_keep_packer

Overview:
- Receiver-side companion to the maxpool engine's AXI-Stream output, which carries sparse per-word tkeep masks.
- Compacts each beat's kept words, in ascending index order, into dense full-width output beats.
- Preserves packet boundaries on tlast and flushes a partial final beat with a low-aligned tkeep.
- Sits between the pooling output stream and the DMA/writer, so memory receives contiguous data.

Parameters:
- WORDS, 16: words per beat; equals the tkeep width.
- WORD_WIDTH, 8: bits per word.

Ports:
- aclk, input, 1: clock.
- aresetn, input, 1: reset, asynchronous, active-low.
- s_axis_tvalid, input, 1: input beat valid.
- s_axis_tready, output, 1: input ready.
- s_axis_tdata, input, WORDS*WORD_WIDTH: input words; word i at bits [i*WORD_WIDTH +: WORD_WIDTH].
- s_axis_tkeep, input, WORDS: bit i=1 means word i is kept.
- s_axis_tlast, input, 1: last beat of packet.
- m_axis_tvalid, output, 1: output beat valid.
- m_axis_tready, input, 1: downstream ready.
- m_axis_tdata, output, WORDS*WORD_WIDTH: packed words; word 0 is the oldest.
- m_axis_tkeep, output, WORDS: all ones, except a final partial beat, which uses low-aligned ones.
- m_axis_tlast, output, 1: packet end.

Behaviour:
- Single clock aclk. Reset is asynchronous on aresetn falling and is released synchronously to aclk.
- State:
  - buffer of 2*WORDS words;
  - count, range 0..2*WORDS, $clog2(2*WORDS)+1 bits;
  - last_pending flag.
- Reset values: count=0, last_pending=0, buffer=0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0.
  - s_axis_tready=1 once aresetn is high.
- s_axis_tready = !last_pending && count <= WORDS. It is registered-state only, with no combinational path from m_axis_tready.
- Output is driven directly from buffer words 0..WORDS-1, with no extra register.
  - m_axis_tvalid = (count >= WORDS) || last_pending.
  - m_axis_tlast = last_pending && count <= WORDS.
  - m_axis_tkeep = all ones if count >= WORDS, else (1<<count)-1.
- pop = m_axis_tvalid && m_axis_tready.
  - Pop removes min(count, WORDS) words from the front and shifts the rest down.
  - If the popped beat has m_axis_tlast=1, last_pending clears.
- push = s_axis_tvalid && s_axis_tready.
  - k = popcount(s_axis_tkeep). Kept words, in ascending input index, are written to positions count_after_pop .. count_after_pop+k-1.
  - Compaction uses the prefix sum of tkeep; kept word i goes to slot count_after_pop + popcount(tkeep[i-1:0]).
  - s_axis_tlast=1 sets last_pending.
- Simultaneous push and pop in one cycle:
  - count_next = count - popped + k;
  - pop is applied first, then the push is appended. Words are never lost or reordered.
  - Maximum count is WORDS + WORDS = 2*WORDS, so no overflow is possible.
- Latency: a word accepted at edge t is visible on m_axis_tdata after edge t, i.e. one cycle.
- Throughput: an all-ones-keep stream with tready=1 sustains one beat per cycle at steady state (count held at WORDS).
- Boundary conditions:
  - keep=0 with tlast=0: beat accepted, no words added.
  - keep=0, tlast=1, count=0: emit one beat with tkeep=0, tlast=1.
  - last_pending with count>WORDS: emit a full beat with tlast=0, then the remainder with tlast=1.
  - last_pending with count==WORDS: one full beat with tlast=1.
  - While last_pending, input is stalled, so packets never merge within a beat.
- AXIS rules: once m_axis_tvalid is asserted, it and tdata/tkeep/tlast hold stable until pop.
- Reset mid-packet: all state clears immediately, buffered words are discarded, and the next packet starts clean.

Test Plan:
Use WORDS=8, WORD_WIDTH=8 for all scenarios.
1. Four beats, keep=0xFF, data ramp 0..31, tlast on beat 4, tready=1 -> four back-to-back output beats, one-cycle latency, tkeep=0xFF, tlast only on beat 4, data 0..31 in order.
2. Two beats keep=0x0F (words 0-3 = 0,1,2,3, then 4,5,6,7), tlast on beat 2 -> one output beat with words 0..7, tkeep=0xFF, tlast=1.
3. Three beats keep=0xAA (odd-index words carry values 1..12), tlast on beat 3 -> beat A: 1..8, tkeep=0xFF, tlast=0; beat B: 9..12, tkeep=0x0F, tlast=1.
4. Full-keep stream with m_axis_tready=0 for 6 cycles -> s_axis_tready drops after the second accepted beat (count=16); on release, 16 words drain in order with no loss or duplication.
5. Single beat keep=0x00, tlast=1, empty buffer -> one output beat with tkeep=0x00, tlast=1; s_axis_tready returns to 1 the cycle after pop.
6. aresetn asserted low asynchronously mid-cycle with count=5 -> m_axis_tvalid=0 without waiting for a clock edge; after release, a new keep=0xFF tlast beat outputs only the new data, tlast=1.
